// File: rtl/am_query_arbiter_pkg.sv
// Shared widths, state encoding and error-response constants for the AM query arbiter.
// The HV/label/distance widths mirror the associative memory this block fronts.
package am_query_arbiter_pkg;

  localparam int HV_DIMENSION   = 64;
  localparam int LABEL_WIDTH    = 8;
  localparam int DISTANCE_WIDTH = 16;

  localparam int AMARB_NUM_REQ = 4;
  localparam int AMARB_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    AMARB_IDLE    = 2'd0,
    AMARB_ISSUE   = 2'd1,
    AMARB_WAIT    = 2'd2,
    AMARB_RESPOND = 2'd3
  } amarb_state_e;

  // A timeout response carries no label and the worst possible distance.
  localparam logic [LABEL_WIDTH-1:0]    AMARB_ERR_LABEL = '0;
  localparam logic [DISTANCE_WIDTH-1:0] AMARB_ERR_DIST  = '1;

endpackage

// File: rtl/am_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr_i+1 and wraps
// modulo NUM_REQ, so the last winner has the lowest priority next time.
module am_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                valid_o
);

  always_comb begin : pick
    logic [ID_WIDTH-1:0] idx;
    grant_o = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        id_o         = idx;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/am_query_arbiter.sv
// Shares one associative memory among NUM_REQ query sources: round-robin grant,
// issue the held query, wait (with watchdog) for the result, return it to the owner.
module am_query_arbiter
  import am_query_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = AMARB_NUM_REQ,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = AMARB_TIMEOUT,
  parameter int TO_CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                              Clk_CI,
  input  logic                              Reset_RI,
  input  logic [NUM_REQ-1:0]                ReqValid_SI,
  output logic [NUM_REQ-1:0]                ReqReady_SO,
  input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHv_mod1_DI,
  input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHv_mod2_DI,
  input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHv_mod3_DI,
  output logic                              AmValid_SO,
  input  logic                              AmReady_SI,
  output logic [HV_DIMENSION-1:0]           AmHv_mod1_DO,
  output logic [HV_DIMENSION-1:0]           AmHv_mod2_DO,
  output logic [HV_DIMENSION-1:0]           AmHv_mod3_DO,
  input  logic                              AmResValid_SI,
  output logic                              AmResReady_SO,
  input  logic [LABEL_WIDTH-1:0]            AmLabelA_DI,
  input  logic [LABEL_WIDTH-1:0]            AmLabelV_DI,
  input  logic [DISTANCE_WIDTH-1:0]         AmDistA_DI,
  input  logic [DISTANCE_WIDTH-1:0]         AmDistV_DI,
  output logic [NUM_REQ-1:0]                RespValid_SO,
  input  logic [NUM_REQ-1:0]                RespReady_SI,
  output logic [ID_WIDTH-1:0]               RespId_DO,
  output logic [LABEL_WIDTH-1:0]            RespLabelA_DO,
  output logic [LABEL_WIDTH-1:0]            RespLabelV_DO,
  output logic [DISTANCE_WIDTH-1:0]         RespDistA_DO,
  output logic [DISTANCE_WIDTH-1:0]         RespDistV_DO,
  output logic                              RespError_SO
);

  amarb_state_e state_q, state_d;

  logic [HV_DIMENSION-1:0]   hv1_q, hv1_d, hv2_q, hv2_d, hv3_q, hv3_d;
  logic [ID_WIDTH-1:0]       id_q, id_d, ptr_q, ptr_d;
  logic [TO_CNT_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic [LABEL_WIDTH-1:0]    label_a_q, label_a_d, label_v_q, label_v_d;
  logic [DISTANCE_WIDTH-1:0] dist_a_q, dist_a_d, dist_v_q, dist_v_d;
  logic                      err_q, err_d;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_WIDTH-1:0] arb_id;
  logic                arb_valid;

  logic [HV_DIMENSION-1:0] hv1_slices [NUM_REQ];
  logic [HV_DIMENSION-1:0] hv2_slices [NUM_REQ];
  logic [HV_DIMENSION-1:0] hv3_slices [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign hv1_slices[gi] = ReqHv_mod1_DI[gi*HV_DIMENSION +: HV_DIMENSION];
      assign hv2_slices[gi] = ReqHv_mod2_DI[gi*HV_DIMENSION +: HV_DIMENSION];
      assign hv3_slices[gi] = ReqHv_mod3_DI[gi*HV_DIMENSION +: HV_DIMENSION];
    end
  endgenerate

  am_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) i_rr (
    .req_i   (ReqValid_SI),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q   <= AMARB_IDLE;
      hv1_q     <= '0;
      hv2_q     <= '0;
      hv3_q     <= '0;
      id_q      <= '0;
      ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
      to_cnt_q  <= '0;
      label_a_q <= '0;
      label_v_q <= '0;
      dist_a_q  <= '0;
      dist_v_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hv1_q     <= hv1_d;
      hv2_q     <= hv2_d;
      hv3_q     <= hv3_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      to_cnt_q  <= to_cnt_d;
      label_a_q <= label_a_d;
      label_v_q <= label_v_d;
      dist_a_q  <= dist_a_d;
      dist_v_q  <= dist_v_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hv1_d     = hv1_q;
    hv2_d     = hv2_q;
    hv3_d     = hv3_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    to_cnt_d  = to_cnt_q;
    label_a_d = label_a_q;
    label_v_d = label_v_q;
    dist_a_d  = dist_a_q;
    dist_v_d  = dist_v_q;
    err_d     = err_q;
    case (state_q)
      AMARB_IDLE: begin
        if (arb_valid) begin
          hv1_d   = hv1_slices[arb_id];
          hv2_d   = hv2_slices[arb_id];
          hv3_d   = hv3_slices[arb_id];
          id_d    = arb_id;
          ptr_d   = arb_id;
          state_d = AMARB_ISSUE;
        end
      end
      AMARB_ISSUE: begin
        if (AmReady_SI) begin
          to_cnt_d = '0;
          state_d  = AMARB_WAIT;
        end
      end
      AMARB_WAIT: begin
        // A result on the last watchdog cycle still takes precedence.
        if (AmResValid_SI) begin
          label_a_d = AmLabelA_DI;
          label_v_d = AmLabelV_DI;
          dist_a_d  = AmDistA_DI;
          dist_v_d  = AmDistV_DI;
          err_d     = 1'b0;
          state_d   = AMARB_RESPOND;
        end else if (to_cnt_q == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          label_a_d = AMARB_ERR_LABEL;
          label_v_d = AMARB_ERR_LABEL;
          dist_a_d  = AMARB_ERR_DIST;
          dist_v_d  = AMARB_ERR_DIST;
          err_d     = 1'b1;
          state_d   = AMARB_RESPOND;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
        end
      end
      AMARB_RESPOND: begin
        if (RespReady_SI[id_q]) begin
          state_d = AMARB_IDLE;
        end
      end
      default: state_d = AMARB_IDLE;
    endcase
  end

  // Result ready stays high outside RESPOND so late AM results are drained and dropped.
  always_comb begin
    ReqReady_SO   = '0;
    AmValid_SO    = 1'b0;
    AmResReady_SO = 1'b0;
    RespValid_SO  = '0;
    case (state_q)
      AMARB_IDLE: begin
        ReqReady_SO   = Reset_RI ? '0 : arb_grant;
        AmResReady_SO = 1'b1;
      end
      AMARB_ISSUE: begin
        AmValid_SO    = 1'b1;
        AmResReady_SO = 1'b1;
      end
      AMARB_WAIT: begin
        AmResReady_SO = 1'b1;
      end
      AMARB_RESPOND: begin
        RespValid_SO[id_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign AmHv_mod1_DO  = hv1_q;
  assign AmHv_mod2_DO  = hv2_q;
  assign AmHv_mod3_DO  = hv3_q;
  assign RespId_DO     = id_q;
  assign RespLabelA_DO = label_a_q;
  assign RespLabelV_DO = label_v_q;
  assign RespDistA_DO  = dist_a_q;
  assign RespDistV_DO  = dist_v_q;
  assign RespError_SO  = err_q;

endmodule

// File: tb/tb_am_query_arbiter.sv
// Bench for am_query_arbiter: the bench plays both the requesters and the AM, and
// predicts grants/responses from the round-robin and watchdog rules.
`timescale 1ns/1ps
module tb_am_query_arbiter;
  import am_query_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;
  localparam int HV  = HV_DIMENSION;
  localparam int LW  = LABEL_WIDTH;
  localparam int DW  = DISTANCE_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ReqValid_SI, ReqReady_SO, RespValid_SO, RespReady_SI;
  logic [N*HV-1:0] ReqHv_mod1_DI, ReqHv_mod2_DI, ReqHv_mod3_DI;
  logic            AmValid_SO, AmReady_SI, AmResValid_SI, AmResReady_SO, RespError_SO;
  logic [HV-1:0]   AmHv_mod1_DO, AmHv_mod2_DO, AmHv_mod3_DO;
  logic [LW-1:0]   AmLabelA_DI, AmLabelV_DI, RespLabelA_DO, RespLabelV_DO;
  logic [DW-1:0]   AmDistA_DI, AmDistV_DI, RespDistA_DO, RespDistV_DO;
  logic [IDW-1:0]  RespId_DO;

  always #5 clk = ~clk;

  am_query_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .Clk_CI(clk), .Reset_RI(rst),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqHv_mod1_DI(ReqHv_mod1_DI), .ReqHv_mod2_DI(ReqHv_mod2_DI), .ReqHv_mod3_DI(ReqHv_mod3_DI),
    .AmValid_SO(AmValid_SO), .AmReady_SI(AmReady_SI),
    .AmHv_mod1_DO(AmHv_mod1_DO), .AmHv_mod2_DO(AmHv_mod2_DO), .AmHv_mod3_DO(AmHv_mod3_DO),
    .AmResValid_SI(AmResValid_SI), .AmResReady_SO(AmResReady_SO),
    .AmLabelA_DI(AmLabelA_DI), .AmLabelV_DI(AmLabelV_DI),
    .AmDistA_DI(AmDistA_DI), .AmDistV_DI(AmDistV_DI),
    .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI), .RespId_DO(RespId_DO),
    .RespLabelA_DO(RespLabelA_DO), .RespLabelV_DO(RespLabelV_DO),
    .RespDistA_DO(RespDistA_DO), .RespDistV_DO(RespDistV_DO),
    .RespError_SO(RespError_SO)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  int last_grant = N - 1;
  logic [HV-1:0] hv1 [N];
  logic [HV-1:0] hv2 [N];
  logic [HV-1:0] hv3 [N];

  task automatic check(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester after the previous winner, wrapping around.
  function automatic int exp_winner(input logic [N-1:0] mask);
    for (int d = 1; d <= N; d++) begin
      if (mask[(last_grant + d) % N]) return (last_grant + d) % N;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, HV'(ReqReady_SO), HV'(0));
    check({tag, "_am_valid"}, HV'(AmValid_SO), HV'(0));
    check({tag, "_resp_valid"}, HV'(RespValid_SO), HV'(0));
    check({tag, "_res_ready"}, HV'(AmResReady_SO), HV'(1));
  endtask

  task automatic check_resp(input int w, input logic [LW-1:0] la, lv,
                            input logic [DW-1:0] da, dv, input logic er);
    check("resp_valid", HV'(RespValid_SO), HV'(N'(1) << w));
    check("resp_id", HV'(RespId_DO), HV'(w));
    check("resp_label_a", HV'(RespLabelA_DO), HV'(la));
    check("resp_label_v", HV'(RespLabelV_DO), HV'(lv));
    check("resp_dist_a", HV'(RespDistA_DO), HV'(da));
    check("resp_dist_v", HV'(RespDistV_DO), HV'(dv));
    check("resp_error", HV'(RespError_SO), HV'(er));
    check("resp_req_ready", HV'(ReqReady_SO), HV'(0));
    check("resp_res_ready", HV'(AmResReady_SO), HV'(0));
  endtask

  task automatic load_hvs();
    for (int i = 0; i < N; i++) begin
      hv1[i] = HV'({$urandom(), $urandom()});
      hv2[i] = HV'({$urandom(), $urandom()});
      hv3[i] = HV'({$urandom(), $urandom()});
      ReqHv_mod1_DI[i*HV +: HV] = hv1[i];
      ReqHv_mod2_DI[i*HV +: HV] = hv2[i];
      ReqHv_mod3_DI[i*HV +: HV] = hv3[i];
    end
  endtask

  // One full query; res_dly >= TO means the AM never answers. Starts and ends on a negedge.
  task automatic run_txn(input logic [N-1:0] mask, input int acc_dly, input int res_dly,
                         input int hold, input bit intrude,
                         input logic [LW-1:0] la, lv, input logic [DW-1:0] da, dv);
    int w;
    logic [N-1:0] oh;
    bit timeout;
    load_hvs();
    ReqValid_SI = mask;
    w  = exp_winner(mask);
    oh = N'(1) << w;
    timeout = (res_dly >= TO);
    #1;
    check("grant", HV'(ReqReady_SO), HV'(oh));
    @(negedge clk);
    last_grant = w;
    #1;
    check("issue_req_ready", HV'(ReqReady_SO), HV'(0));
    check("issue_am_valid", HV'(AmValid_SO), HV'(1));
    check("issue_res_ready", HV'(AmResReady_SO), HV'(1));
    check("issue_hv1", AmHv_mod1_DO, hv1[w]);
    check("issue_hv2", AmHv_mod2_DO, hv2[w]);
    check("issue_hv3", AmHv_mod3_DO, hv3[w]);
    for (int c = 0; c < acc_dly; c++) begin
      @(negedge clk); #1;
      check("issue_hold_valid", HV'(AmValid_SO), HV'(1));
    end
    AmReady_SI = 1'b1;
    @(negedge clk);
    AmReady_SI = 1'b0;
    AmLabelA_DI = la; AmLabelV_DI = lv; AmDistA_DI = da; AmDistV_DI = dv;
    for (int c = 0; c < TO; c++) begin
      #1;
      check("wait_res_ready", HV'(AmResReady_SO), HV'(1));
      check("wait_no_resp", HV'(RespValid_SO), HV'(0));
      check("wait_am_valid", HV'(AmValid_SO), HV'(0));
      if (!timeout && c == res_dly) begin
        AmResValid_SI = 1'b1;
        @(negedge clk);
        AmResValid_SI = 1'b0;
        break;
      end
      @(negedge clk);
    end
    RespReady_SI = intrude ? ~oh : '0;
    for (int c = 0; c < hold; c++) begin
      #1;
      if (timeout) check_resp(w, '0, '0, '1, '1, 1'b1);
      else         check_resp(w, la, lv, da, dv, 1'b0);
      @(negedge clk);
    end
    RespReady_SI = oh;
    #1;
    if (timeout) check_resp(w, '0, '0, '1, '1, 1'b1);
    else         check_resp(w, la, lv, da, dv, 1'b0);
    @(negedge clk);
    RespReady_SI = '0;
    ReqValid_SI  = '0;
    #1;
    check_idle("back_idle");
    $display("txn %0d mask=%b winner=%0d acc=%0d res=%0d hold=%0d intrude=%0b timeout=%0b",
             txn, mask, w, acc_dly, res_dly, hold, intrude, timeout);
    txn++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ReqValid_SI = '0; RespReady_SI = '0; AmReady_SI = 1'b0; AmResValid_SI = 1'b0;
    ReqHv_mod1_DI = '0; ReqHv_mod2_DI = '0; ReqHv_mod3_DI = '0;
    AmLabelA_DI = '0; AmLabelV_DI = '0; AmDistA_DI = '0; AmDistV_DI = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_hv1", AmHv_mod1_DO, HV'(0));
    check("reset_error", HV'(RespError_SO), HV'(0));
    check("reset_dist_a", HV'(RespDistA_DO), HV'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All four valid continuously: expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      run_txn(4'b1111, 0, 0, 0, 1'b0, LW'($urandom), LW'($urandom), DW'($urandom), DW'($urandom));

    // Single requester 2; AM answers 20 cycles after issue (8 accept + 12 compute).
    run_txn(4'b0100, 8, 12, 0, 1'b0, LW'(1), LW'(5), DW'(37), DW'(99));

    // AM never answers -> timeout, then a late stale result in IDLE is dropped.
    run_txn(4'b0010, 1, TO, 1, 1'b0, LW'(7), LW'(7), DW'(7), DW'(7));
    AmResValid_SI = 1'b1;
    #1;
    check("stale_res_ready", HV'(AmResReady_SO), HV'(1));
    @(negedge clk);
    AmResValid_SI = 1'b0;
    #1;
    check_idle("stale_drop");
    @(negedge clk);
    run_txn(4'b1000, 0, 3, 0, 1'b0, LW'($urandom), LW'($urandom), DW'($urandom), DW'($urandom));

    // Result coinciding with the last watchdog cycle wins.
    run_txn(4'b0001, 0, TO - 1, 0, 1'b0, LW'(9), LW'(3), DW'(12), DW'(34));

    // Owner holds ready low 10 cycles while a non-owner asserts ready.
    run_txn(4'b0110, 2, 4, 10, 1'b1, LW'($urandom), LW'($urandom), DW'($urandom), DW'($urandom));

    for (int i = 0; i < 12; i++)
      run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 20),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              LW'($urandom), LW'($urandom), DW'($urandom), DW'($urandom));

    // Asynchronous reset in the middle of WAIT.
    load_hvs();
    ReqValid_SI = 4'b1000;
    #1;
    check("rst_grant", HV'(ReqReady_SO), HV'(exp_winner(4'b1000) == 3 ? 4'b1000 : 4'b0000));
    @(negedge clk);
    AmReady_SI = 1'b1;
    @(negedge clk);
    AmReady_SI = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_hv1", AmHv_mod1_DO, HV'(0));
    check("rst_async_id", HV'(RespId_DO), HV'(0));
    check("rst_async_am_valid", HV'(AmValid_SO), HV'(0));
    check("rst_async_resp_valid", HV'(RespValid_SO), HV'(0));
    check("rst_async_res_ready", HV'(AmResReady_SO), HV'(1));
    check("rst_async_req_ready", HV'(ReqReady_SO), HV'(0));
    ReqValid_SI = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    last_grant = N - 1;
    @(negedge clk);
    run_txn(4'b1111, 0, 2, 0, 1'b0, LW'($urandom), LW'($urandom), DW'($urandom), DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
